// File: rtl/regfile_dump_reader.sv
// Streams every register-file entry as an address/data word, reading two
// registers per pass through the register file's combinational read ports.
module regfile_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] Ard1,
   output logic [ADDR_W-1:0] Ard2,
   input  logic [DATA_W-1:0] Dout1,
   input  logic [DATA_W-1:0] Dout2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   localparam int KW    = ADDR_W - 1;
   localparam int PAIRS = NUM_REGS / 2;
   localparam logic [KW-1:0] LAST_K = KW'(PAIRS - 1);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      SEND_LO,
      SEND_HI,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [KW-1:0]     k;
   logic [KW-1:0]     k_nxt;
   logic [DATA_W-1:0] h1;
   logic [DATA_W-1:0] h2;

   // Read addresses come straight from the pair counter so they never glitch.
   assign Ard1 = {k, 1'b0};
   assign Ard2 = {k, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         k     <= '0;
         h1    <= '0;
         h2    <= '0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
         if (state == READ) begin
            h1 <= Dout1;
            h2 <= Dout2;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      busy      = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_addr  = '0;
      out_data  = '0;
      unique case (state)
         IDLE: begin
            k_nxt = '0;
            if (start) begin
               state_nxt = READ;
            end
         end
         READ: begin
            busy      = 1'b1;
            state_nxt = SEND_LO;
         end
         SEND_LO: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_addr  = {k, 1'b0};
            out_data  = h1;
            if (out_ready) begin
               state_nxt = SEND_HI;
            end
         end
         SEND_HI: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_addr  = {k, 1'b1};
            out_data  = h2;
            out_last  = (k == LAST_K);
            if (out_ready) begin
               if (k == LAST_K) begin
                  state_nxt = DONE;
               end else begin
                  k_nxt     = k + KW'(1);
                  state_nxt = READ;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            k_nxt     = '0;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            k_nxt     = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: a register-file model feeds the
// read ports, expected words are queued up front and checked by a monitor.
module tb_regfile_dump_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic [4:0]  Ard1;
   logic [4:0]  Ard2;
   logic [31:0] Dout1;
   logic [31:0] Dout2;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic        out_last;

   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rf [32];

   int total = 0;
   int bad   = 0;
   int words = 0;
   int done_cnt = 0;
   logic [37:0] exp_q [$];

   regfile_dump_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .Ard1      (Ard1),
      .Ard2      (Ard2),
      .Dout1     (Dout1),
      .Dout2     (Dout2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wr_en) rf[wr_addr] <= wr_data;
   end

   assign Dout1 = rf[Ard1];
   assign Dout2 = rf[Ard2];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops on every handshake, checks hold-stability under stall.
   logic        pv = 1'b0;
   logic [37:0] pw = '0;
   always @(negedge clk) begin
      logic [37:0] cur;
      cur = {out_last, out_addr, out_data};
      if (rst) begin
         pv = 1'b0;
      end else begin
         chk("last_without_valid", 64'(out_last & ~out_valid), 64'd0);
         if (pv) chk("stall_hold", {out_valid, cur}, {1'b1, pw});
         if (out_valid && out_ready) begin
            words++;
            if (exp_q.size() == 0) begin
               chk("unexpected_word", cur, 38'h0);
               bad += (cur == 38'h0) ? 1 : 0;
            end else begin
               chk("word", cur, exp_q.pop_front());
            end
         end
         if (done) done_cnt++;
         pv = out_valid && !out_ready;
         pw = cur;
      end
   end

   task automatic load_all();
      for (int r = 0; r < 32; r++) begin
         wr_en   = 1'b1;
         wr_addr = 5'(r);
         wr_data = 32'hA5A50000 + r;
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
   endtask

   task automatic push_exp(input int n, input bit patched);
      logic [31:0] d;
      for (int r = 0; r < n; r++) begin
         d = 32'hA5A50000 + r;
         if (patched && r == 5) d = 32'hDEADBEEF;
         exp_q.push_back({(r == 31), 5'(r), d});
      end
   endtask

   // mode: 0 plain, 1 stall on reg 3, 2 writes mid-dump,
   //       3 extra start while busy, 4 reset after word 10
   task automatic dump(input int mode, input int exp_lat);
      int lat;
      int left;
      bit stalled;
      bit seen;
      int d0;
      int w0;
      d0 = done_cnt;
      w0 = words;
      left = 0;
      stalled = 0;
      seen = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      chk("read_state", {busy, out_valid}, 2'b10);
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         lat++;
         wr_en = 1'b0;
         if (lat == 1) chk("first_valid", 64'(out_valid), 64'd1);
         if (done) begin
            seen = 1;
            break;
         end
         if (mode == 1) begin
            if (left > 0) begin
               left--;
               if (left == 0) out_ready = 1'b1;
            end else if (!stalled && out_valid && out_addr == 5'd3) begin
               out_ready = 1'b0;
               left = 5;
               stalled = 1;
            end
         end
         if (mode == 2 && out_valid && !out_last) begin
            if (out_addr == 5'd2) begin
               wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
            end
            if (out_addr == 5'd4) begin
               wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hCAFEF00D;
            end
         end
         if (mode == 3) start = (lat == 10);
         if (mode == 4 && out_valid && out_ready && out_addr == 5'd10) begin
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_ard", {Ard1, Ard2}, {5'd0, 5'd1});
            chk("rst_done", 64'(done), 64'd0);
            rst = 1'b0;
            seen = 1;
            break;
         end
      end
      start = 1'b0;
      wr_en = 1'b0;
      out_ready = 1'b1;
      if (mode == 4) begin
         chk("rst_reached", 64'(seen), 64'd1);
         repeat (3) @(posedge clk);
         #1;
         chk("rst_words", 64'(words - w0), 64'd11);
         chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
      end else begin
         chk("done_seen", 64'(seen), 64'd1);
         chk("done_latency", 64'(lat), 64'(exp_lat));
         @(posedge clk); #1;
         chk("after_done", {busy, done}, 2'b00);
         repeat (3) @(posedge clk);
         #1;
         chk("idle_busy", 64'(busy), 64'd0);
         chk("word_count", 64'(words - w0), 64'd32);
         chk("done_pulses", 64'(done_cnt - d0), 64'd1);
      end
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", {busy, done, out_valid, out_last}, 4'b0000);
      chk("reset_ard", {Ard1, Ard2}, {5'd0, 5'd1});
      chk("reset_out", {out_addr, out_data}, 37'd0);
      rst = 1'b0;
      load_all();
      push_exp(32, 0);
      dump(0, 48);
      push_exp(32, 0);
      dump(1, 53);
      push_exp(32, 1);
      dump(2, 48);
      load_all();
      push_exp(32, 0);
      dump(3, 48);
      push_exp(11, 0);
      dump(4, 0);
      push_exp(32, 0);
      dump(0, 48);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
